freq_select: RTL and testbench

Downstream consumer of the 2 Hz / 5 Hz / 9 Hz divider outputs. It picks one of the three square waves under control of a (possibly asynchronous) 2-bit select. It drives the chosen wave out glitch-free and emits a one-cycle tick on each rising edge of the chosen wave. A wrapping tick counter is provided for display logic.

---
 rtl/freq_select.sv | 120 ++++++++++++
 tb/tb_freq_select.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_select.sv
// Glitch-free selector for the 2/5/9 Hz divider waves.
// Emits a tick per rising edge of the chosen wave and counts ticks.
module freq_select #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       q_in,
  input  logic [1:0]       sel,
  input  logic             clr,
  output logic             f_out,
  output logic             tick,
  output logic [CNT_W-1:0] tick_cnt,
  output logic [1:0]       active_sel,
  output logic             busy
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    PARK
  } state_t;

  state_t     state, state_n;
  logic [2:0] q_d, q_q, rise;
  logic [1:0] sel_m, sel_s;
  logic [1:0] target, target_n, active_n;
  logic       busy_n, f_n, tick_n;
  logic       src_a, rise_a, src_t;

  function automatic logic pick(
    input logic [2:0] v,
    input logic [1:0] c
  );
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (c == 2'b00): r = v[2];
      (c == 2'b01): r = v[1];
      (c == 2'b10): r = v[0];
      default:      r = 1'b0;
    endcase
    return r;
  endfunction

  assign rise   = q_d & ~q_q;
  assign src_a  = pick(q_d, active_sel);
  assign rise_a = pick(rise, active_sel);
  assign src_t  = pick(q_d, target);

  // Old source must drain low, then new source must be low before handover.
  always_comb begin
    state_n  = state;
    target_n = target;
    active_n = active_sel;
    busy_n   = busy;
    f_n      = 1'b0;
    tick_n   = 1'b0;
    unique case (state)
      RUN: begin
        f_n    = src_a;
        tick_n = rise_a;
        if (sel_s != active_sel) begin
          target_n = sel_s;
          busy_n   = 1'b1;
          state_n  = DRAIN;
        end
      end
      DRAIN: begin
        f_n = src_a;
        if (!src_a) state_n = PARK;
      end
      PARK: begin
        if (!src_t) begin
          active_n = target;
          busy_n   = 1'b0;
          state_n  = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      target     <= 2'b00;
      active_sel <= 2'b00;
      busy       <= 1'b0;
      f_out      <= 1'b0;
      tick       <= 1'b0;
      q_d        <= 3'b000;
      q_q        <= 3'b000;
      sel_m      <= 2'b00;
      sel_s      <= 2'b00;
    end else begin
      state      <= state_n;
      target     <= target_n;
      active_sel <= active_n;
      busy       <= busy_n;
      f_out      <= f_n;
      tick       <= tick_n;
      q_d        <= q_in;
      q_q        <= q_d;
      sel_m      <= sel;
      sel_s      <= sel_m;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (clr) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_freq_select.sv
// Bench for freq_select: cycle model plus directed
// scenarios with hand-derived expectations.
module tb_freq_select;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       q_in;
  logic [1:0]       sel;
  logic             clr;
  logic             f_out;
  logic             tick;
  logic [CNT_W-1:0] tick_cnt;
  logic [1:0]       active_sel;
  logic             busy;

  int errors = 0;
  int checks = 0;

  freq_select #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .q_in(q_in),
    .sel(sel),
    .clr(clr),
    .f_out(f_out),
    .tick(tick),
    .tick_cnt(tick_cnt),
    .active_sel(active_sel),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // model: last two sampled waves, select delay line, switch phase
  bit [2:0] m_q1, m_q2;
  bit [1:0] m_sa, m_sb;
  int       phase;
  bit [1:0] m_tgt, m_act;
  bit       m_busy, m_f, m_tick;
  int       m_cnt;

  int ticks, busy_cycles, run;
  bit width_chk, rec;
  int seq[$];
  int last_rec;

  function automatic bit wave(bit [2:0] v, bit [1:0] c);
    if (c == 2'd3) return 1'b0;
    return v[2 - int'(c)];
  endfunction

  task automatic model_reset();
    m_q1 = 0; m_q2 = 0; m_sa = 0; m_sb = 0;
    phase = 0; m_tgt = 0; m_act = 0;
    m_busy = 0; m_f = 0; m_tick = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit [2:0] rs;
    bit s, r, st;
    int cnt_n;
    if (!reset) begin
      model_reset();
      return;
    end
    rs = m_q1 & ~m_q2;
    s  = wave(m_q1, m_act);
    r  = wave(rs, m_act);
    st = wave(m_q1, m_tgt);
    cnt_n = clr ? 0 : (m_cnt + int'(m_tick)) % (1 << CNT_W);
    m_f = 0;
    m_tick = 0;
    if (phase == 0) begin
      m_f = s;
      m_tick = r;
      if (m_sb != m_act) begin
        m_tgt = m_sb; m_busy = 1; phase = 1;
      end
    end else if (phase == 1) begin
      m_f = s;
      if (!s) phase = 2;
    end else begin
      if (!st) begin
        m_act = m_tgt; m_busy = 0; phase = 0;
      end
    end
    m_cnt = cnt_n;
    m_q2 = m_q1; m_q1 = q_in;
    m_sb = m_sa; m_sa = sel;
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("f_out", 32'(f_out), 32'(m_f));
    check("tick", 32'(tick), 32'(m_tick));
    check("tick_cnt", 32'(tick_cnt), 32'(m_cnt));
    check("active_sel", 32'(active_sel), 32'(m_act));
    check("busy", 32'(busy), 32'(m_busy));
    if (tick === 1'b1) ticks++;
    if (busy === 1'b1) busy_cycles++;
    if (f_out === 1'b1) run++;
    else begin
      if (width_chk && run > 0) begin
        checks++;
        if (run < 6) begin
          errors++;
          $display("FAIL f_pulse_len: got %0d required >= 6", run);
        end
      end
      run = 0;
    end
    if (rec && int'(tick_cnt) != last_rec) begin
      last_rec = int'(tick_cnt);
      seq.push_back(last_rec);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1 compare_all();
    end
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; sel = 2'b10; q_in = 3'b000;
    width_chk = 0; rec = 0; run = 0; ticks = 0; busy_cycles = 0;
    last_rec = 0;
    model_reset();

    // reset held with toggling inputs
    for (int i = 0; i < 6; i++) begin
      q_in = (i % 2 == 1) ? 3'b111 : 3'b000;
      cyc(1);
    end
    check("rst_act", 32'(active_sel), 0);
    check("rst_f", 32'(f_out), 0);
    q_in = 3'b000;
    reset = 1'b1;
    cyc(1); check("busy_e1", 32'(busy), 0);
    cyc(1); check("busy_e2", 32'(busy), 0);
    cyc(1); check("busy_e3", 32'(busy), 1);
    cyc(2);
    check("act_10", 32'(active_sel), 2);
    check("busy_done", 32'(busy), 0);

    // steady 2 Hz
    sel = 2'b00;
    cyc(6);
    clr = 1'b1; cyc(1); clr = 1'b0;
    ticks = 0; busy_cycles = 0;
    repeat (5) begin
      q_in = 3'b100; cyc(6);
      q_in = 3'b000; cyc(6);
    end
    cyc(2);
    check("ticks_2hz", ticks, 5);
    check("cnt_2hz", 32'(tick_cnt), 5);
    check("busy_2hz", busy_cycles, 0);

    // glitch-free 00 -> 01 with both high
    width_chk = 1; run = 0;
    q_in = 3'b110; cyc(3);
    sel = 2'b01; cyc(4);
    check("gl_busy", 32'(busy), 1);
    check("gl_f_hold", 32'(f_out), 1);
    q_in = 3'b010; cyc(6);
    check("gl_park_f", 32'(f_out), 0);
    check("gl_park_busy", 32'(busy), 1);
    q_in = 3'b000; cyc(4);
    check("gl_act", 32'(active_sel), 1);
    check("gl_busy_off", 32'(busy), 0);
    ticks = 0;
    repeat (2) begin
      q_in = 3'b010; cyc(6);
      q_in = 3'b000; cyc(6);
    end
    check("gl_ticks", ticks, 2);
    width_chk = 0;

    // switch to off
    sel = 2'b11; busy_cycles = 0; ticks = 0;
    cyc(6);
    check("off_busy_len", busy_cycles, 2);
    check("off_act", 32'(active_sel), 3);
    repeat (3) begin
      q_in = 3'b111; cyc(3);
      q_in = 3'b000; cyc(3);
    end
    check("off_ticks", ticks, 0);

    // retarget during DRAIN
    sel = 2'b00; cyc(6);
    check("rt_act0", 32'(active_sel), 0);
    q_in = 3'b100; cyc(3);
    sel = 2'b01; cyc(3);
    check("rt_busy", 32'(busy), 1);
    sel = 2'b10; cyc(3);
    check("rt_drain", 32'(busy), 1);
    check("rt_still0", 32'(active_sel), 0);
    q_in = 3'b000; cyc(3);
    check("rt_first", 32'(active_sel), 1);
    cyc(3);
    check("rt_second", 32'(active_sel), 2);
    check("rt_idle", 32'(busy), 0);

    // counter wrap on 9 Hz
    clr = 1'b1; cyc(1); clr = 1'b0;
    rec = 1; last_rec = 0;
    repeat (9) begin
      q_in = 3'b001; cyc(2);
      q_in = 3'b000; cyc(2);
    end
    cyc(2);
    rec = 0;
    check("wrap_final", 32'(tick_cnt), 1);
    check("wrap_len", 32'(seq.size() >= 3), 1);
    if (seq.size() >= 3) begin
      check("wrap_m2", seq[seq.size()-3], 7);
      check("wrap_m1", seq[seq.size()-2], 0);
      check("wrap_m0", seq[seq.size()-1], 1);
    end

    // clr coincident with tick
    q_in = 3'b001; cyc(2);
    check("clr_tick_hi", 32'(tick), 1);
    clr = 1'b1; cyc(1); clr = 1'b0;
    check("clr_wins", 32'(tick_cnt), 0);
    q_in = 3'b000; cyc(3);

    // async reset while parked
    q_in = 3'b010; sel = 2'b01;
    cyc(5);
    check("park_busy", 32'(busy), 1);
    check("park_f", 32'(f_out), 0);
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("ar_busy", 32'(busy), 0);
    check("ar_act", 32'(active_sel), 0);
    cyc(2);
    reset = 1'b1;
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
